uart_rx_engine: RTL and testbench

Serial receive engine for the full UART. It synchronizes the asynchronous `rx` line, detects and validates a start bit, and samples each bit at mid-bit-time using a programmable baud divisor. It assembles a 7- or 8-bit character with optional parity and reports parity, framing and overrun errors. It is the receive counterpart of the UART transmit engine and hands characters to the processor-side register interface.

---
 rtl/uart_rx_engine.sv | 140 ++++++++++++++
 tb/tb_uart_rx_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, validates the start bit, samples mid-bit
// using a runtime baud divisor and reports data plus parity/framing/overrun status.
module uart_rx_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [18:0] baud_k,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic        clr_rdy,
    output logic [7:0]  data,
    output logic        rx_rdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q;
    logic        rx_m_q, rx_s_q, rx_s_prev_q;
    logic [18:0] baud_q, tgt_q, cnt_q;
    logic        eight_q, pen_q, ohel_q;
    logic [3:0]  bit_cnt_q;
    logic [9:0]  sh_q;

    logic        fall_d, expire_d;
    logic [3:0]  nsamp_d;
    logic [9:0]  just_d;
    logic [7:0]  data_d;
    logic        par_d, stop_d, perr_d;

    assign dbg_state_o = state_q;

    assign fall_d   = rx_s_prev_q & ~rx_s_q;
    assign expire_d = (cnt_q == tgt_q - 19'd1);

    // Samples after the start bit: data bits, optional parity, one stop bit.
    assign nsamp_d = 4'd8 + {3'b000, eight_q} + {3'b000, pen_q};
    assign just_d  = sh_q >> (4'd10 - nsamp_d);
    assign data_d  = eight_q ? just_d[7:0] : {1'b0, just_d[6:0]};
    assign par_d   = eight_q ? just_d[8] : just_d[7];
    assign stop_d  = just_d[nsamp_d - 4'd1];
    assign perr_d  = pen_q & (^data_d ^ par_d ^ ohel_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m_q      <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_s_prev_q <= 1'b1;
        end else begin
            rx_m_q      <= rx;
            rx_s_q      <= rx_m_q;
            rx_s_prev_q <= rx_s_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            tgt_q     <= '0;
            cnt_q     <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            data      <= '0;
            rx_rdy    <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            // A read strobe clears status; a completing frame below overrides it.
            if (clr_rdy) begin
                rx_rdy <= 1'b0;
                perr   <= 1'b0;
                ferr   <= 1'b0;
                ovf    <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (fall_d) begin
                        baud_q  <= baud_k;
                        eight_q <= eight;
                        pen_q   <= pen;
                        ohel_q  <= ohel;
                        tgt_q   <= baud_k >> 1;
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (expire_d) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            tgt_q     <= baud_q;
                            bit_cnt_q <= '0;
                            sh_q      <= '0;
                            state_q   <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 19'd1;
                    end
                end
                DATA: begin
                    if (expire_d) begin
                        cnt_q     <= '0;
                        sh_q      <= {rx_s_q, sh_q[9:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q + 4'd1 == nsamp_d)
                            state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 19'd1;
                    end
                end
                DONE: begin
                    data    <= data_d;
                    perr    <= perr_d;
                    ferr    <= ~stop_d;
                    rx_rdy  <= 1'b1;
                    ovf     <= ~clr_rdy & (ovf | rx_rdy);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: table of directed frames plus hand-written sequences
// for latency, glitch, overrun, simultaneous read and mid-frame reset.
module tb_uart_rx_engine;

    logic        clk = 1'b0;
    logic        rst, rx, eight, pen, ohel, clr_rdy;
    logic [18:0] baud_k;
    logic [7:0]  data;
    logic        rx_rdy, perr, ferr, ovf;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int         baud;
        logic       eight;
        logic       pen;
        logic       ohel;
        logic [7:0] ch;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[11];
    int   lat;
    bit   seen;
    bit   any_high;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd3;

    always #5 clk = ~clk;

    uart_rx_engine dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .baud_k     (baud_k),
        .eight      (eight),
        .pen        (pen),
        .ohel       (ohel),
        .clr_rdy    (clr_rdy),
        .data       (data),
        .rx_rdy     (rx_rdy),
        .perr       (perr),
        .ferr       (ferr),
        .ovf        (ovf),
        .dbg_state_o(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg(input int baud, input logic e, input logic p, input logic o);
        baud_k = 19'(baud);
        eight  = e;
        pen    = p;
        ohel   = o;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    // Called on a negedge; leaves rx at the stop-bit level when it returns.
    task automatic send_frame(input logic [7:0] ch, input int nd, input logic use_par,
                              input logic par, input logic stop, input int baud);
        rx = 1'b0;
        repeat (baud) @(negedge clk);
        for (int i = 0; i < nd; i++) begin
            rx = ch[i];
            repeat (baud) @(negedge clk);
        end
        if (use_par) begin
            rx = par;
            repeat (baud) @(negedge clk);
        end
        rx = stop;
        repeat (baud) @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic e_rdy, input logic e_perr,
                               input logic e_ferr, input logic e_ovf);
        check({tag, " rx_rdy"}, rx_rdy, e_rdy);
        check({tag, " perr"}, perr, e_perr);
        check({tag, " ferr"}, ferr, e_ferr);
        check({tag, " ovf"}, ovf, e_ovf);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           baud eight pen  ohel  ch     par   stop  data   perr  ferr
        vecs[0]  = '{16, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{16, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[2]  = '{16, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[3]  = '{16, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[4]  = '{16, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[5]  = '{16, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        vecs[6]  = '{16, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[7]  = '{12, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[8]  = '{4,  1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0};
        vecs[9]  = '{5,  1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[10] = '{16, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};

        rst = 1'b1;
        rx = 1'b1;
        clr_rdy = 1'b0;
        cfg(16, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset data", data, 8'h00);
        check_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset state", dbg_state, S_IDLE);

        any_high = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (data != 8'h00 || rx_rdy || perr || ferr || ovf || dbg_state != S_IDLE)
                any_high = 1'b1;
        end
        check("idle 100 clocks quiet", any_high, 1'b0);

        // Latency: counted in clocks from the edge that first registers rx low.
        cfg(16, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'hA5);
        lat = 0;
        seen = 1'b0;
        fork
            send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                @(posedge clk);
                for (int i = 1; i <= 400 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (rx_rdy) begin
                        seen = 1'b1;
                        lat = i;
                    end
                end
            end
        join
        @(negedge clk);
        rx = 1'b1;
        check("latency rx_rdy seen", seen, 1'b1);
        check("latency clocks", lat, 155);
        check("latency data", data, exp_q.pop_front());
        check_flags("latency", 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            pulse_clr();
            cfg(vecs[i].baud, vecs[i].eight, vecs[i].pen, vecs[i].ohel);
            exp_q.push_back(vecs[i].exp_data);
            send_frame(vecs[i].ch, vecs[i].eight ? 8 : 7, vecs[i].pen, vecs[i].par,
                       vecs[i].stop, vecs[i].baud);
            rx = 1'b1;
            repeat (4) @(negedge clk);
            check($sformatf("v%0d data", i), data, exp_q.pop_front());
            check_flags($sformatf("v%0d", i), 1'b1, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0);
        end

        // Glitch: short low pulse must be rejected at the start check.
        pulse_clr();
        cfg(16, 1'b1, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch in start", dbg_state, S_START);
        repeat (40) @(negedge clk);
        check("glitch back to idle", dbg_state, S_IDLE);
        check("glitch data kept", data, 8'hFF);
        check_flags("glitch", 1'b0, 1'b0, 1'b0, 1'b0);

        // Overrun: two back-to-back frames with no read in between.
        pulse_clr();
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 16);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 16);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("overrun data", data, 8'h22);
        check_flags("overrun", 1'b1, 1'b0, 1'b0, 1'b1);

        // Read strobe lands on the DONE clock of the second frame.
        pulse_clr();
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 16);
        fork
            send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, 16);
            begin
                repeat (155) @(negedge clk);
                check("simul read on done", dbg_state, S_DONE);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("simul data", data, 8'h44);
        check_flags("simul", 1'b1, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        check_flags("after clr", 1'b0, 1'b0, 1'b0, 1'b0);
        check("after clr data", data, 8'h44);

        // Reset in the middle of a frame.
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("pre-reset data", data, 8'h5A);
        check("pre-reset rx_rdy", rx_rdy, 1'b1);
        rx = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset data", data, 8'h00);
        check("midreset rx_rdy", rx_rdy, 1'b0);
        check("midreset state", dbg_state, S_IDLE);
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("post-reset rx_rdy", rx_rdy, 1'b0);
        check("post-reset data", data, 8'h00);
        check("post-reset state", dbg_state, S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
